// File: rtl/cordic_job_controller.sv
// cordic_job_controller
//    Issues vectoring/rotation jobs to a fixed-latency CORDIC core, tracks
//    each job through the core pipeline, and collects the results in a
//    first-word-fall-through FIFO. Issue is credit-limited so the FIFO
//    cannot overflow. The core's mode input is shared by all of its stages,
//    so a job whose mode differs from the jobs in flight waits until the
//    pipeline has drained.
//
//    Ports
//       clock, reset_n              system clock, async active-low reset
//       in_valid/in_ready           job handshake
//       in_x/in_y/in_angle/in_mode  job operands and mode (01 is illegal)
//       in_tag                      user tag returned with the result
//       core_x/y/angle/mode         registered drive into the core
//       core_rx/ry/rangle           core results
//       out_valid/out_ready         result handshake (FIFO head)
//       out_x/y/angle/tag/err       result fields
//       busy                        jobs in flight or results pending
//
//    state  | meaning
//    IDLE   | nothing in flight; any request is accepted
//    RUN    | jobs in flight; same-mode requests accepted while credits last
//    DRAIN  | mode change requested; waiting for the pipeline to empty
module cordic_job_controller #(
   parameter int LATENCY    = 17,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_x,
   input  logic [31:0]          in_y,
   input  logic [31:0]          in_angle,
   input  logic [1:0]           in_mode,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic [31:0]          core_x,
   output logic [31:0]          core_y,
   output logic [31:0]          core_angle,
   output logic [1:0]           core_mode,
   input  logic [31:0]          core_rx,
   input  logic [31:0]          core_ry,
   input  logic [31:0]          core_rangle,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_x,
   output logic [31:0]          out_y,
   output logic [31:0]          out_angle,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic                 out_err,
   output logic                 busy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int EW = 97 + TAG_WIDTH;
   localparam logic [CW:0]   CREDITS = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [1:0]    MODE_CIRC = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [31:0]            core_x_q, core_x_d, core_y_q, core_y_d;
   logic [31:0]            core_angle_q, core_angle_d;
   logic [1:0]             core_mode_q, core_mode_d;
   logic [CW-1:0]          inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                   sr_vld_q [LATENCY];
   logic                   sr_vld_d [LATENCY];
   logic [TAG_WIDTH-1:0]   sr_tag_q [LATENCY];
   logic [TAG_WIDTH-1:0]   sr_tag_d [LATENCY];
   logic                   sr_err_q [LATENCY];
   logic                   sr_err_d [LATENCY];
   logic [EW-1:0]          fifo_q [FIFO_DEPTH];
   logic [EW-1:0]          fifo_d [FIFO_DEPTH];

   logic [1:0]    mode_eff;
   logic          mode_err, mode_ok, credit_ok, accept, retire, fifo_rd;
   logic [CW:0]   credits_used;
   logic [EW-1:0] head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Illegal mode 01 runs as CIRCULAR and is flagged on the result.
   assign mode_err     = (in_mode == 2'b01);
   assign mode_eff     = mode_err ? MODE_CIRC : in_mode;
   assign mode_ok      = (inflight_q == '0) || (mode_eff == core_mode_q);
   assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
   assign credit_ok    = (credits_used < CREDITS);
   assign in_ready     = reset_n && credit_ok && (state_q != S_DRAIN) && mode_ok;
   assign accept       = in_valid && in_ready;
   assign retire       = sr_vld_q[LATENCY-1];
   assign out_valid    = (fifo_cnt_q != '0);
   assign fifo_rd      = out_valid && out_ready;
   assign busy         = (inflight_q != '0) || out_valid;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RUN;
         S_RUN: begin
            if (accept)                      state_d = S_RUN;
            else if (in_valid && !mode_ok)   state_d = S_DRAIN;
            else if (inflight_q == '0)       state_d = S_IDLE;
         end
         S_DRAIN: if (inflight_q == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      core_x_d     = core_x_q;
      core_y_d     = core_y_q;
      core_angle_d = core_angle_q;
      core_mode_d  = core_mode_q;
      if (accept) begin
         core_x_d     = in_x;
         core_y_d     = in_y;
         core_angle_d = in_angle;
         core_mode_d  = mode_eff;
      end
      inflight_d = inflight_q + CW'(accept) - CW'(retire);
      fifo_cnt_d = fifo_cnt_q + CW'(retire) - CW'(fifo_rd);
      wr_ptr_d   = retire  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = fifo_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;

      sr_vld_d[0] = accept;
      sr_tag_d[0] = in_tag;
      sr_err_d[0] = mode_err;
      for (int i = 1; i < LATENCY; i++) begin
         sr_vld_d[i] = sr_vld_q[i-1];
         sr_tag_d[i] = sr_tag_q[i-1];
         sr_err_d[i] = sr_err_q[i-1];
      end

      fifo_d = fifo_q;
      if (retire)
         fifo_d[wr_ptr_q] = {sr_err_q[LATENCY-1], sr_tag_q[LATENCY-1],
                             core_rx, core_ry, core_rangle};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         core_x_q     <= '0;
         core_y_q     <= '0;
         core_angle_q <= '0;
         core_mode_q  <= MODE_CIRC;
         inflight_q   <= '0;
         fifo_cnt_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            sr_vld_q[i] <= 1'b0;
            sr_tag_q[i] <= '0;
            sr_err_q[i] <= 1'b0;
         end
      end else begin
         state_q      <= state_d;
         core_x_q     <= core_x_d;
         core_y_q     <= core_y_d;
         core_angle_q <= core_angle_d;
         core_mode_q  <= core_mode_d;
         inflight_q   <= inflight_d;
         fifo_cnt_q   <= fifo_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         sr_vld_q     <= sr_vld_d;
         sr_tag_q     <= sr_tag_d;
         sr_err_q     <= sr_err_d;
      end
   end

   // Storage needs no reset: the outputs are gated by out_valid.
   always_ff @(posedge clock) begin
      fifo_q <= fifo_d;
   end

   assign head       = fifo_q[rd_ptr_q];
   assign out_err    = out_valid && head[EW-1];
   assign out_tag    = out_valid ? head[EW-2 -: TAG_WIDTH] : '0;
   assign out_x      = out_valid ? head[95:64] : '0;
   assign out_y      = out_valid ? head[63:32] : '0;
   assign out_angle  = out_valid ? head[31:0]  : '0;
   assign core_x     = core_x_q;
   assign core_y     = core_y_q;
   assign core_angle = core_angle_q;
   assign core_mode  = core_mode_q;

   a_fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(retire && (fifo_cnt_q == DEPTH_C)));

endmodule

// File: tb/tb_cordic_job_controller.sv
module tb_cordic_job_controller;
   localparam int LATENCY = 17, FIFO_DEPTH = 4, TAG_WIDTH = 4;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic                 in_valid, in_ready, out_valid, out_ready, out_err, busy;
   logic [31:0]          in_x, in_y, in_angle, core_x, core_y, core_angle;
   logic [31:0]          core_rx, core_ry, core_rangle, out_x, out_y, out_angle;
   logic [1:0]           in_mode, core_mode;
   logic [TAG_WIDTH-1:0] in_tag, out_tag;

   cordic_job_controller #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_WIDTH(TAG_WIDTH)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_angle(in_angle), .in_mode(in_mode), .in_tag(in_tag),
      .core_x(core_x), .core_y(core_y), .core_angle(core_angle), .core_mode(core_mode),
      .core_rx(core_rx), .core_ry(core_ry), .core_rangle(core_rangle),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
      .out_angle(out_angle), .out_tag(out_tag), .out_err(out_err), .busy(busy));

   // Core stand-in: the controller's input register is the first of the
   // LATENCY stages, so the remaining LATENCY-1 live here.
   logic [95:0] pipe [LATENCY-1];
   always @(posedge clock) begin
      pipe[0] <= {core_x + 32'd1, core_y + 32'd2, core_angle + 32'd3};
      for (int i = 1; i < LATENCY-1; i++) pipe[i] <= pipe[i-1];
   end
   assign core_rx     = pipe[LATENCY-2][95:64];
   assign core_ry     = pipe[LATENCY-2][63:32];
   assign core_rangle = pipe[LATENCY-2][31:0];

   typedef struct {
      logic [31:0] x, y, a;
      logic [TAG_WIDTH-1:0] tag;
      logic err;
      int acc_cyc;
   } job_t;

   job_t model_q[$];
   int   n_checks = 0, n_errors = 0, cyc = 0;
   bit   last_acc, last_pop;
   logic [1:0] last_mode = 2'b10;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic logic [1:0] eff_mode(input logic [1:0] m);
      return (m == 2'b01) ? 2'b10 : m;
   endfunction

   // One clock: observe handshakes at the falling edge, update the
   // reference model, then return 1 ns after the rising edge.
   task automatic tick();
      int nin;
      job_t j;
      @(negedge clock);
      last_acc = 0;
      last_pop = 0;
      if (in_ready) chk("credit_bound", model_q.size() < FIFO_DEPTH, 1);
      if (out_valid && out_ready) begin
         chk("result_has_job", model_q.size() == 0, 0);
         if (model_q.size() != 0) begin
            j = model_q.pop_front();
            chk("out_x", out_x, j.x);
            chk("out_y", out_y, j.y);
            chk("out_angle", out_angle, j.a);
            chk("out_tag", out_tag, j.tag);
            chk("out_err", out_err, j.err);
            last_pop = 1;
         end
      end
      if (in_valid && in_ready) begin
         nin = 0;
         foreach (model_q[k]) if (cyc - model_q[k].acc_cyc <= LATENCY) nin++;
         if (nin > 0) chk("mode_shared", eff_mode(in_mode), last_mode);
         j.x = in_x + 32'd1; j.y = in_y + 32'd2; j.a = in_angle + 32'd3;
         j.tag = in_tag; j.err = (in_mode == 2'b01); j.acc_cyc = cyc;
         model_q.push_back(j);
         last_mode = eff_mode(in_mode);
         last_acc = 1;
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic set_job(input logic [31:0] x, y, a, input logic [1:0] m, input logic [TAG_WIDTH-1:0] t);
      in_valid = 1; in_x = x; in_y = y; in_angle = a; in_mode = m; in_tag = t;
   endtask

   task automatic drain(input string name);
      int n;
      in_valid = 0; out_ready = 1; n = 0;
      while ((model_q.size() != 0 || busy) && n < 200) begin tick(); n++; end
      chk(name, model_q.size(), 0);
      out_ready = 0;
   endtask

   task automatic single_job(input string name);
      int n;
      out_ready = 0;
      set_job(32'h0010_0000, 32'h0, 32'h1000_0000, 2'b10, 4'd3);
      tick();
      chk({name, "_accept"}, last_acc, 1);
      in_valid = 0;
      chk({name, "_core_x"}, core_x, 32'h0010_0000);
      chk({name, "_core_mode"}, core_mode, 2'b10);
      n = 0;
      while (!out_valid && n < 60) begin tick(); n++; end
      chk({name, "_latency"}, n, LATENCY);
      chk({name, "_x"}, out_x, 32'h0010_0001);
      chk({name, "_y"}, out_y, 32'h2);
      chk({name, "_angle"}, out_angle, 32'h1000_0003);
      chk({name, "_tag"}, out_tag, 4'd3);
      chk({name, "_err"}, out_err, 0);
      tick();
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_x"}, out_x, 32'h0010_0001);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk({name, "_popped"}, out_valid, 0);
      chk({name, "_idle"}, busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, pops, burst, n, seen;
      logic [1:0] cur_mode;
      logic [1:0] mode_tbl [4];
      mode_tbl = '{2'b00, 2'b10, 2'b11, 2'b01};
      in_valid = 0; out_ready = 0; in_x = 0; in_y = 0; in_angle = 0; in_mode = 2'b10; in_tag = 0;
      reset_n = 1;
      #1 reset_n = 0;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_core_mode", core_mode, 2'b10);
      chk("rst_core_x", core_x, 0);
      chk("rst_out_x", out_x, 0);
      @(posedge clock); #1;
      reset_n = 1;
      tick();
      chk("idle_in_ready", in_ready, 1);

      // single CIRCULAR job
      single_job("t1");

      // six LINEAR jobs against a stalled output
      acc = 0;
      for (int c = 0; c < 30; c++) begin
         if (acc < 6) set_job(32'h1000 * acc, 32'h20 + acc, 32'h300 + acc, 2'b00, TAG_WIDTH'(acc));
         else in_valid = 0;
         tick();
         if (last_acc) acc++;
      end
      chk("t2_accepted", acc, 4);
      chk("t2_in_ready", in_ready, 0);
      chk("t2_out_valid", out_valid, 1);
      out_ready = 1; pops = 0; burst = 0;
      for (int c = 0; c < 80 && pops < 6; c++) begin
         if (acc < 6) set_job(32'h1000 * acc, 32'h20 + acc, 32'h300 + acc, 2'b00, TAG_WIDTH'(acc));
         else in_valid = 0;
         tick();
         if (last_acc) acc++;
         if (last_pop) begin pops++; if (c < 4) burst++; end
      end
      chk("t2_pops", pops, 6);
      chk("t2_burst", burst, 4);
      drain("t2_drain");

      // mode change waits for the pipeline to drain
      set_job(32'h0004_0000, 32'h1, 32'h2, 2'b10, 4'd1);
      tick();
      chk("t3_accept1", last_acc, 1);
      set_job(32'h0005_0000, 32'h3, 32'h4, 2'b11, 4'd2);
      n = 0;
      while (n < 60) begin
         tick(); n++;
         if (last_acc) break;
         chk("t3_mode_hold", core_mode, 2'b10);
      end
      chk("t3_accept_cycle", n, LATENCY + 2);
      chk("t3_core_mode", core_mode, 2'b11);
      drain("t3_drain");

      // illegal mode
      set_job(32'h7, 32'h8, 32'h9, 2'b01, 4'd7);
      tick();
      chk("t4_accept", last_acc, 1);
      in_valid = 0;
      chk("t4_core_mode", core_mode, 2'b10);
      n = 0;
      while (!out_valid && n < 60) begin tick(); n++; end
      chk("t4_err", out_err, 1);
      chk("t4_tag", out_tag, 4'd7);
      drain("t4_drain");

      // asynchronous reset mid-pipeline
      for (int k = 0; k < 3; k++) begin
         set_job(32'hABC0 + k, 32'h11, 32'h22, 2'b10, TAG_WIDTH'(10 + k));
         tick();
      end
      in_valid = 0;
      repeat (5) tick();
      #3 reset_n = 0;
      #1;
      chk("t5_core_x", core_x, 0);
      chk("t5_core_y", core_y, 0);
      chk("t5_core_angle", core_angle, 0);
      chk("t5_core_mode", core_mode, 2'b10);
      chk("t5_in_ready", in_ready, 0);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_busy", busy, 0);
      #2 reset_n = 1;
      model_q.delete();
      @(posedge clock); #1; cyc++;
      seen = 0;
      repeat (40) begin tick(); if (out_valid) seen++; end
      chk("t5_no_result", seen, 0);
      chk("t5_busy_after", busy, 0);
      single_job("t5_post");

      // pop and retire on the same edge with two entries held
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         set_job(32'h500 + k, 32'h600, 32'h700, 2'b10, TAG_WIDTH'(8 + k));
         tick();
         chk("t6_accept", last_acc, 1);
      end
      in_valid = 0;
      repeat (LATENCY - 1) tick();
      chk("t6_valid", out_valid, 1);
      chk("t6_head0", out_tag, 4'd8);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("t6_pop", last_pop, 1);
      chk("t6_head1", out_tag, 4'd9);
      out_ready = 1;
      tick();
      chk("t6_head2", out_tag, 4'd10);
      chk("t6_valid2", out_valid, 1);
      tick();
      chk("t6_empty", out_valid, 0);
      out_ready = 0;

      // randomized traffic
      cur_mode = 2'b00;
      in_valid = 0;
      for (int c = 0; c < 300; c++) begin
         if (!in_valid || last_acc) begin
            if ($urandom_range(0, 3) != 0) begin
               if ($urandom_range(0, 7) == 0) cur_mode = mode_tbl[$urandom_range(0, 3)];
               set_job($urandom, $urandom, $urandom, cur_mode, TAG_WIDTH'($urandom));
            end else in_valid = 0;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      n = 0;
      out_ready = 1;
      while (in_valid && n < 100) begin tick(); n++; if (last_acc) in_valid = 0; end
      chk("rand_pending_accepted", in_valid, 0);
      drain("rand_drain");
      chk("rand_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
